// File: rtl/game_pkg.sv
// Shared game-state encodings for the dino game sequencer and its downstream blocks.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
//
// Contents:
//   gs_t / GS_*          : 2-bit game-state encoding driven on game_state_ctrl.gs
//   *_DEF                : default timing parameters for a 25 MHz pixel clock
//   gs_is_halted()       : world-freeze rule as seen by score/obstacle/sprite blocks
package game_pkg;

  typedef logic [1:0] gs_t;

  localparam gs_t GS_IDLE   = 2'd0;
  localparam gs_t GS_RUN    = 2'd1;
  localparam gs_t GS_OVER   = 2'd2;
  localparam gs_t GS_PAUSED = 2'd3;

  // 10 ms of button stability at 25 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEF     = 250000;
  // About half a second at 60 Hz before a restart is accepted.
  localparam int unsigned OVER_HOLDOFF_FRAMES_DEF = 30;
  // GAME OVER text blinks at 2 Hz at 60 Hz.
  localparam int unsigned BLINK_FRAMES_DEF        = 15;

  // The world only moves while running; every other state freezes it.
  function automatic logic gs_is_halted(input gs_t gs);
    return gs != GS_RUN;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
// Latency: clean input edge to press = 2 + CYCLES clk cycles.
// Backpressure: none; press is a fire-and-forget single-cycle pulse.
//
// Ports:
//   clk      in   pixel clock
//   reset_n  in   asynchronous active-low reset; clears synchroniser and debounce state
//   btn_raw  in   raw asynchronous button, active-high
//   level    out  debounced button level
//   press    out  one-cycle pulse on the debounced 0->1 transition
module btn_debounce #(
  parameter int unsigned CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  // Counter only has to reach CYCLES-1: the CYCLES-th differing sample flips level.
  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Any sample equal to the current level restarts the stability window,
  // so level only moves after CYCLES consecutive differing samples.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level dino game sequencer: debounces jump (and optionally pause) and runs IDLE/RUN/OVER(/PAUSED).
// Latency: every output is registered; a state change appears one cycle after its cause.
// Backpressure: none; jump_pulse and score_reset are single-cycle strobes, consumers must take them.
//
// Build option: define GAME_PAUSE_EN to add btn_pause and the PAUSED state (gs=3).
//
// Ports:
//   clk          in   pixel clock, single domain
//   reset_n      in   asynchronous active-low reset
//   btn_jump     in   raw jump/start button, active-high
//   collision    in   dino/obstacle overlap level, only honoured in RUN
//   frame_tick   in   one-cycle pulse per video frame
//   btn_pause    in   raw pause button (GAME_PAUSE_EN only)
//   gs           out  game state, game_pkg GS_* encoding
//   halt         out  world frozen (all states except RUN)
//   jump_pulse   out  one-cycle jump request to dino physics
//   score_reset  out  one-cycle clear to the score counter
//   over_blink   out  GAME OVER text blink enable, 0 outside OVER
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned OVER_HOLDOFF_FRAMES = OVER_HOLDOFF_FRAMES_DEF,
  parameter int unsigned BLINK_FRAMES        = BLINK_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_jump,
  input  logic       collision,
  input  logic       frame_tick,
`ifdef GAME_PAUSE_EN
  input  logic       btn_pause,
`endif
  output logic [1:0] gs,
  output logic       halt,
  output logic       jump_pulse,
  output logic       score_reset,
  output logic       over_blink
);

  localparam int HOLD_W  = $clog2(OVER_HOLDOFF_FRAMES + 1);
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = GS_IDLE,
    ST_RUN    = GS_RUN,
    ST_OVER   = GS_OVER
`ifdef GAME_PAUSE_EN
    , ST_PAUSED = GS_PAUSED
`endif
  } state_e;

  // ------------------------------------------------------------------
  // Button conditioning
  // ------------------------------------------------------------------
  logic jump_press;
  logic jump_level_unused;

  btn_debounce #(
    .CYCLES  (DEBOUNCE_CYCLES)
  ) u_jump_db (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (btn_jump),
    .level   (jump_level_unused),
    .press   (jump_press)
  );

`ifdef GAME_PAUSE_EN
  logic pause_press;
  logic pause_level_unused;

  btn_debounce #(
    .CYCLES  (DEBOUNCE_CYCLES)
  ) u_pause_db (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (btn_pause),
    .level   (pause_level_unused),
    .press   (pause_press)
  );
`endif

  // ------------------------------------------------------------------
  // OVER-state counters: next values computed here, sequenced by the FSM
  // ------------------------------------------------------------------
  state_e             state_q;
  logic               halt_q;
  logic               jump_q;
  logic               score_reset_q;
  logic               blink_q;
  logic [HOLD_W-1:0]  hold_q,      hold_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               hold_done;
  logic               blink_wrap;

  // Holdoff saturates so it can never wrap back into the "discard presses" range.
  assign hold_done   = (hold_q == HOLD_W'(OVER_HOLDOFF_FRAMES));
  assign hold_d      = hold_done ? hold_q : hold_q + 1'b1;

  assign blink_wrap  = (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1));
  assign blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;

  // ------------------------------------------------------------------
  // Game state machine with registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      halt_q        <= 1'b1;
      jump_q        <= 1'b0;
      score_reset_q <= 1'b0;
      blink_q       <= 1'b0;
      hold_q        <= '0;
      blink_cnt_q   <= '0;
    end else begin
      // Strobes default low so each can only ever last one cycle.
      jump_q        <= 1'b0;
      score_reset_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          // The start press only starts the game; it is not also a jump.
          if (jump_press) begin
            state_q       <= ST_RUN;
            halt_q        <= 1'b0;
            score_reset_q <= 1'b1;
          end
        end

        ST_RUN: begin
          // Collision outranks everything: a press landing in the crash cycle
          // must not make the dino jump out of the obstacle.
          if (collision) begin
            state_q     <= ST_OVER;
            halt_q      <= 1'b1;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
          end
`ifdef GAME_PAUSE_EN
          else if (pause_press) begin
            state_q <= ST_PAUSED;
            halt_q  <= 1'b1;
          end
`endif
          else if (jump_press) begin
            jump_q <= 1'b1;
          end
        end

        ST_OVER: begin
          // Presses during holdoff are simply dropped, so a player still
          // hammering jump at the crash does not instantly restart.
          if (jump_press && hold_done) begin
            state_q       <= ST_RUN;
            halt_q        <= 1'b0;
            score_reset_q <= 1'b1;
            blink_q       <= 1'b0;
          end else if (frame_tick) begin
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
            if (blink_wrap) begin
              blink_q <= ~blink_q;
            end
          end
        end

`ifdef GAME_PAUSE_EN
        ST_PAUSED: begin
          // Resume keeps the score; jump and collision are deliberately ignored.
          if (pause_press) begin
            state_q <= ST_RUN;
            halt_q  <= 1'b0;
          end
        end
`endif

        default: begin
          state_q <= ST_IDLE;
          halt_q  <= 1'b1;
          blink_q <= 1'b0;
        end
      endcase
    end
  end

  assign gs          = state_q;
  assign halt        = halt_q;
  assign jump_pulse  = jump_q;
  assign score_reset = score_reset_q;
  assign over_blink  = blink_q;

endmodule
